dpic_mem_port: RTL and testbench

//  Clocked, parametrised simulation memory port backed by DPI-C pmem_read/pmem_write.

---
 rtl/dpic_mem_port_if.sv | 62 ++++++
 rtl/dpic_mem_port.sv | 212 +++++++++++++++++++++
 tb/tb_dpic_mem_port.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpic_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module  : dpic_mem_port_if
// Purpose : read/write request-response channels plus the pmem call bundle
// Rev     : 1.0
// ============================================================================
interface dpic_mem_port_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int c_STRB_W = DATA_W / 8;

  // Read channel
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic                rresp;

  // Write channel (address, data and strobe share one beat)
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [DATA_W-1:0]   wdata;
  logic [c_STRB_W-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic                bresp;

  // pmem_read / pmem_write calls, serviced on the clock edge where *_en is high
  logic                pm_rd_en;
  logic [63:0]         pm_rd_addr;
  logic [63:0]         pm_rd_data;
  logic                pm_wr_en;
  logic [63:0]         pm_wr_addr;
  logic [63:0]         pm_wr_data;
  logic [7:0]          pm_wr_mask;

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp,
    input  awvalid, awaddr, wdata, wstrb, bready,
    output awready, bvalid, bresp,
    output pm_rd_en, pm_rd_addr, pm_wr_en, pm_wr_addr, pm_wr_data, pm_wr_mask,
    input  pm_rd_data
  );

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp,
    output awvalid, awaddr, wdata, wstrb, bready,
    input  awready, bvalid, bresp
  );

  modport mem (
    input  pm_rd_en, pm_rd_addr, pm_wr_en, pm_wr_addr, pm_wr_data, pm_wr_mask,
    output pm_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/dpic_mem_port.sv
`default_nettype none
// ============================================================================
// Module  : dpic_mem_port
// Purpose : latency-programmable simulation memory port, independent read and
//           write channels; DPIC_MEM_ALIGN_CHK_EN enables alignment errors
// Rev     : 1.0
// ============================================================================
module dpic_mem_port #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 1
) (
  input wire             clock,
  input wire             reset_n,
  dpic_mem_port_if.slave bus
);

  localparam int c_STRB_W = DATA_W / 8;
  localparam int c_CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_rd_state;
  state_t              w_rd_state_nxt;
  logic [c_CNT_W-1:0]  r_rd_cnt;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rresp;

  state_t              r_wr_state;
  state_t              w_wr_state_nxt;
  logic [c_CNT_W-1:0]  r_wr_cnt;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_STRB_W-1:0] r_wstrb;
  logic                r_bresp;

  logic                w_rd_accept;
  logic                w_rd_call;
  logic                w_rd_misalign;
  logic                w_rd_dpi;
  logic [63:0]         w_rd_addr_ext;
  logic [63:0]         w_rd_addr64;
  logic [63:0]         w_rd_word;
  logic [DATA_W-1:0]   w_rd_lane;

  logic                w_wr_accept;
  logic                w_wr_call;
  logic                w_wr_misalign;
  logic                w_wr_dpi;
  logic                w_wr_hit;
  logic [63:0]         w_wr_addr_ext;
  logic [63:0]         w_wr_addr64;
  logic [63:0]         w_wr_data64;
  logic [7:0]          w_wr_mask8;
  logic [63:0]         w_wr_bmask64;
  logic                w_unused_ok;

  // ------------------------------------------------------------------------
  // Read channel FSM
  // ------------------------------------------------------------------------
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      S_IDLE:  if (bus.arvalid)      w_rd_state_nxt = S_WAIT;
      S_WAIT:  if (r_rd_cnt == '0)   w_rd_state_nxt = S_RESP;
      S_RESP:  if (bus.rready)       w_rd_state_nxt = S_IDLE;
      default:                       w_rd_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd_accept = (r_rd_state == S_IDLE) && bus.arvalid;
  assign w_rd_call   = (r_rd_state == S_WAIT) && (r_rd_cnt == '0) && reset_n;
  assign w_rd_dpi    = w_rd_call && !w_rd_misalign;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_state <= S_IDLE;
      r_rd_cnt   <= '0;
      r_rd_addr  <= '0;
      r_rdata    <= '0;
      r_rresp    <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      if (w_rd_accept) begin
        r_rd_addr <= bus.araddr;
        r_rd_cnt  <= c_CNT_LOAD;
      end else if ((r_rd_state == S_WAIT) && (r_rd_cnt != '0)) begin
        r_rd_cnt <= r_rd_cnt - c_CNT_W'(1);
      end
      if (w_rd_call) begin
        r_rdata <= w_rd_misalign ? '0 : w_rd_lane;
        r_rresp <= w_rd_misalign;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Write channel FSM
  // ------------------------------------------------------------------------
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      S_IDLE:  if (bus.awvalid)      w_wr_state_nxt = S_WAIT;
      S_WAIT:  if (r_wr_cnt == '0)   w_wr_state_nxt = S_RESP;
      S_RESP:  if (bus.bready)       w_wr_state_nxt = S_IDLE;
      default:                       w_wr_state_nxt = S_IDLE;
    endcase
  end

  assign w_wr_accept = (r_wr_state == S_IDLE) && bus.awvalid;
  assign w_wr_call   = (r_wr_state == S_WAIT) && (r_wr_cnt == '0) && reset_n;
  // An all-zero strobe still completes the handshake but never touches memory
  assign w_wr_dpi    = w_wr_call && !w_wr_misalign && (r_wstrb != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_state <= S_IDLE;
      r_wr_cnt   <= '0;
      r_wr_addr  <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      if (w_wr_accept) begin
        r_wr_addr <= bus.awaddr;
        r_wdata   <= bus.wdata;
        r_wstrb   <= bus.wstrb;
        r_wr_cnt  <= c_CNT_LOAD;
      end else if ((r_wr_state == S_WAIT) && (r_wr_cnt != '0)) begin
        r_wr_cnt <= r_wr_cnt - c_CNT_W'(1);
      end
      if (w_wr_call) begin
        r_bresp <= w_wr_misalign;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Alignment check
  // ------------------------------------------------------------------------
`ifdef DPIC_MEM_ALIGN_CHK_EN
  localparam int c_OFF_W = $clog2(c_STRB_W);
  assign w_rd_misalign = (r_rd_addr[c_OFF_W-1:0] != '0);
  assign w_wr_misalign = (r_wr_addr[c_OFF_W-1:0] != '0);
`else
  assign w_rd_misalign = 1'b0;
  assign w_wr_misalign = 1'b0;
`endif

  // ------------------------------------------------------------------------
  // Address, lane and mask formation
  // ------------------------------------------------------------------------
  assign w_rd_addr_ext = 64'(r_rd_addr);
  assign w_wr_addr_ext = 64'(r_wr_addr);
  assign w_rd_addr64   = {w_rd_addr_ext[63:3], 3'b000};
  assign w_wr_addr64   = {w_wr_addr_ext[63:3], 3'b000};

  generate
    if (DATA_W == 64) begin : g_d64
      assign w_rd_lane   = w_rd_word;
      assign w_wr_data64 = r_wdata;
      assign w_wr_mask8  = r_wstrb;
    end else begin : g_d32
      assign w_rd_lane   = r_rd_addr[2] ? w_rd_word[63:32] : w_rd_word[31:0];
      assign w_wr_data64 = r_wr_addr[2] ? {r_wdata, 32'h0} : {32'h0, r_wdata};
      assign w_wr_mask8  = r_wr_addr[2] ? {r_wstrb, 4'h0}  : {4'h0, r_wstrb};
    end
  endgenerate

  generate
    for (genvar i = 0; i < 8; i++) begin : g_bmask
      assign w_wr_bmask64[8*i +: 8] = {8{w_wr_mask8[i]}};
    end
  endgenerate

  // Memory returns pre-edge contents; a same-edge write to the same doubleword
  // is folded in so the read observes the write as having happened first.
  assign w_wr_hit  = w_wr_dpi && w_rd_dpi && (w_wr_addr64 == w_rd_addr64);
  assign w_rd_word = w_wr_hit ?
                     ((bus.pm_rd_data & ~w_wr_bmask64) | (w_wr_data64 & w_wr_bmask64)) :
                     bus.pm_rd_data;

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign bus.arready    = (r_rd_state == S_IDLE);
  assign bus.rvalid     = (r_rd_state == S_RESP);
  assign bus.rdata      = r_rdata;
  assign bus.rresp      = r_rresp;

  assign bus.awready    = (r_wr_state == S_IDLE);
  assign bus.bvalid     = (r_wr_state == S_RESP);
  assign bus.bresp      = r_bresp;

  assign bus.pm_rd_en   = w_rd_dpi;
  assign bus.pm_rd_addr = w_rd_addr64;
  assign bus.pm_wr_en   = w_wr_dpi;
  assign bus.pm_wr_addr = w_wr_addr64;
  assign bus.pm_wr_data = w_wr_data64;
  assign bus.pm_wr_mask = w_wr_mask8;

  assign w_unused_ok = ^{w_rd_addr_ext[2:0], w_wr_addr_ext[2:0], w_rd_word, r_rd_addr, r_wr_addr};

endmodule
`default_nettype wire

// File: tb/tb_dpic_mem_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_dpic_mem_port
// Purpose : directed + random checks of dpic_mem_port (64b/LAT3 and 32b/LAT1)
// Rev     : 1.0
// ============================================================================
module tb_dpic_mem_port;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  dpic_mem_port_if #(.ADDR_W(64), .DATA_W(64)) if64 ();
  dpic_mem_port_if #(.ADDR_W(64), .DATA_W(32)) if32 ();

  dpic_mem_port #(.ADDR_W(64), .DATA_W(64), .LATENCY(3)) u_dut64 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if64.slave)
  );

  dpic_mem_port #(.ADDR_W(64), .DATA_W(32), .LATENCY(1)) u_dut32 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if32.slave)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_rcall64 = 0, n_wcall64 = 0, n_rcall32 = 0, n_wcall32 = 0;
  logic [7:0]  last_mask32;
  logic [63:0] last_waddr32;

  // pmem stand-ins: present old contents before the edge, then commit the write
  logic [63:0] mem64 [logic [63:0]];
  logic [63:0] mem32 [logic [63:0]];

  always @(negedge clock) begin : p_mem64
    logic [63:0] t;
    if64.pm_rd_data = mem64.exists(if64.pm_rd_addr) ? mem64[if64.pm_rd_addr] : 64'h0;
    if (if64.pm_rd_en) n_rcall64++;
    if (if64.pm_wr_en) begin
      t = mem64.exists(if64.pm_wr_addr) ? mem64[if64.pm_wr_addr] : 64'h0;
      for (int i = 0; i < 8; i++)
        if (if64.pm_wr_mask[i]) t[8*i +: 8] = if64.pm_wr_data[8*i +: 8];
      mem64[if64.pm_wr_addr] = t;
      n_wcall64++;
    end
  end

  always @(negedge clock) begin : p_mem32
    logic [63:0] t;
    if32.pm_rd_data = mem32.exists(if32.pm_rd_addr) ? mem32[if32.pm_rd_addr] : 64'h0;
    if (if32.pm_rd_en) n_rcall32++;
    if (if32.pm_wr_en) begin
      t = mem32.exists(if32.pm_wr_addr) ? mem32[if32.pm_wr_addr] : 64'h0;
      for (int i = 0; i < 8; i++)
        if (if32.pm_wr_mask[i]) t[8*i +: 8] = if32.pm_wr_data[8*i +: 8];
      mem32[if32.pm_wr_addr] = t;
      last_mask32  = if32.pm_wr_mask;
      last_waddr32 = if32.pm_wr_addr;
      n_wcall32++;
    end
  end

  // Reference model: byte-addressed view of memory, one map per port
  logic [7:0] ref64 [logic [63:0]];
  logic [7:0] ref32 [logic [63:0]];

  function automatic void ref_wr(input bit is32, input logic [63:0] a,
                                 input logic [63:0] d, input logic [7:0] s);
    logic [63:0] base;
    base = a - (a % 8);
    if (!is32) begin
      for (int i = 0; i < 8; i++) if (s[i]) ref64[base + 64'(i)] = d[8*i +: 8];
    end else begin
      base = base + ((a % 8) >= 4 ? 64'd4 : 64'd0);
      for (int i = 0; i < 4; i++) if (s[i]) ref32[base + 64'(i)] = d[8*i +: 8];
    end
  endfunction

  function automatic logic [63:0] ref_rd(input bit is32, input logic [63:0] a);
    logic [63:0] base, v;
    v = 64'h0;
    base = a - (a % 8);
    if (!is32) begin
      for (int i = 0; i < 8; i++)
        if (ref64.exists(base + 64'(i))) v[8*i +: 8] = ref64[base + 64'(i)];
    end else begin
      base = base + ((a % 8) >= 4 ? 64'd4 : 64'd0);
      for (int i = 0; i < 4; i++)
        if (ref32.exists(base + 64'(i))) v[8*i +: 8] = ref32[base + 64'(i)];
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Channel tasks: entered and left #1 after a rising edge with the channel idle
  task automatic rd64(input logic [63:0] a, output logic [63:0] d, output logic r, output int lat);
    if64.arvalid = 1'b1;
    if64.araddr  = a;
    @(posedge clock); #1;
    if64.arvalid = 1'b0;
    lat = 1;
    while (!if64.rvalid && lat < 40) begin @(posedge clock); #1; lat++; end
    d = if64.rdata;
    r = if64.rresp;
    if64.rready = 1'b1;
    @(posedge clock); #1;
    if64.rready = 1'b0;
  endtask

  task automatic wr64(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                      output logic r, output int lat);
    if64.awvalid = 1'b1;
    if64.awaddr  = a;
    if64.wdata   = d;
    if64.wstrb   = s;
    @(posedge clock); #1;
    if64.awvalid = 1'b0;
    lat = 1;
    while (!if64.bvalid && lat < 40) begin @(posedge clock); #1; lat++; end
    r = if64.bresp;
    if64.bready = 1'b1;
    @(posedge clock); #1;
    if64.bready = 1'b0;
  endtask

  task automatic rd32(input logic [63:0] a, output logic [63:0] d, output logic r, output int lat);
    if32.arvalid = 1'b1;
    if32.araddr  = a;
    @(posedge clock); #1;
    if32.arvalid = 1'b0;
    lat = 1;
    while (!if32.rvalid && lat < 40) begin @(posedge clock); #1; lat++; end
    d = 64'(if32.rdata);
    r = if32.rresp;
    if32.rready = 1'b1;
    @(posedge clock); #1;
    if32.rready = 1'b0;
  endtask

  task automatic wr32(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic r, output int lat);
    if32.awvalid = 1'b1;
    if32.awaddr  = a;
    if32.wdata   = d;
    if32.wstrb   = s;
    @(posedge clock); #1;
    if32.awvalid = 1'b0;
    lat = 1;
    while (!if32.bvalid && lat < 40) begin @(posedge clock); #1; lat++; end
    r = if32.bresp;
    if32.bready = 1'b1;
    @(posedge clock); #1;
    if32.bready = 1'b0;
  endtask

  initial begin : p_watchdog
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_main
    logic [63:0] a, d, d2, exp;
    logic [31:0] lo;
    logic [7:0]  s;
    logic        r, r2;
    int          lat, lat2, rc, wc;

    reset_n = 1'b0;
    if64.arvalid = 1'b0; if64.araddr = '0; if64.rready = 1'b0;
    if64.awvalid = 1'b0; if64.awaddr = '0; if64.wdata = '0; if64.wstrb = '0; if64.bready = 1'b0;
    if32.arvalid = 1'b0; if32.araddr = '0; if32.rready = 1'b0;
    if32.awvalid = 1'b0; if32.awaddr = '0; if32.wdata = '0; if32.wstrb = '0; if32.bready = 1'b0;

    // Reset values
    @(posedge clock); #1;
    chk("rst_arready", 64'(if64.arready), 64'd1);
    chk("rst_awready", 64'(if64.awready), 64'd1);
    chk("rst_rvalid",  64'(if64.rvalid),  64'd0);
    chk("rst_bvalid",  64'(if64.bvalid),  64'd0);
    chk("rst_rdata",   if64.rdata,        64'd0);
    chk("rst_resp",    64'({if64.rresp, if64.bresp}), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // 64-bit, LATENCY=3: full write then read back
    wr64(64'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF, r, lat);
    ref_wr(1'b0, 64'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF);
    chk("t2_bresp", 64'(r), 64'd0);
    chk("t2_wlat",  64'(lat), 64'd4);
    rd64(64'h8000_0000, d, r, lat);
    chk("t2_rdata", d, 64'h1122_3344_5566_7788);
    chk("t2_rresp", 64'(r), 64'd0);
    chk("t2_rlat",  64'(lat), 64'd4);

    // 32-bit lanes, LATENCY=1
    lo = $urandom;
    wr32(64'h8000_0000, lo, 4'hF, r, lat);
    ref_wr(1'b1, 64'h8000_0000, 64'(lo), 8'h0F);
    wr32(64'h8000_0004, 32'hDEAD_BEEF, 4'hF, r, lat);
    ref_wr(1'b1, 64'h8000_0004, 64'hDEAD_BEEF, 8'h0F);
    chk("t3_mask",  64'(last_mask32), 64'hF0);
    chk("t3_waddr", last_waddr32, 64'h8000_0000);
    chk("t3_wlat",  64'(lat), 64'd2);
    rd32(64'h8000_0000, d, r, lat);
    chk("t3_rd_lo", d, ref_rd(1'b1, 64'h8000_0000));
    rd32(64'h8000_0004, d, r, lat);
    chk("t3_rd_hi", d, 64'hDEAD_BEEF);
    chk("t3_rlat",  64'(lat), 64'd2);

    // Backpressure on the read response
    if64.arvalid = 1'b1;
    if64.araddr  = 64'h8000_0000;
    @(posedge clock); #1;
    if64.arvalid = 1'b0;
    lat = 1;
    while (!if64.rvalid && lat < 40) begin @(posedge clock); #1; lat++; end
    chk("t4_lat", 64'(lat), 64'd4);
    exp = ref_rd(1'b0, 64'h8000_0000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      chk("t4_rvalid_hold",  64'(if64.rvalid),  64'd1);
      chk("t4_rdata_hold",   if64.rdata,        exp);
      chk("t4_arready_low",  64'(if64.arready), 64'd0);
    end
    if64.rready = 1'b1;
    chk("t4_arready_hs", 64'(if64.arready), 64'd0);
    @(posedge clock); #1;
    if64.rready = 1'b0;
    chk("t4_arready_after", 64'(if64.arready), 64'd1);
    chk("t4_rvalid_after",  64'(if64.rvalid),  64'd0);

    // Reset asserted while a read is waiting
    rc = n_rcall64;
    if64.arvalid = 1'b1;
    if64.araddr  = 64'h8000_0000;
    @(posedge clock); #1;
    if64.arvalid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("t1_no_call",  64'(n_rcall64 - rc), 64'd0);
    chk("t1_arready",  64'(if64.arready),   64'd1);
    chk("t1_rvalid",   64'(if64.rvalid),    64'd0);
    chk("t1_rdata",    if64.rdata,          64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("t1_no_call_after", 64'(n_rcall64 - rc), 64'd0);
    chk("t1_rvalid_after",  64'(if64.rvalid),    64'd0);

    // Same-edge read and write with LATENCY=1: read sees the new value
    chk("t5_old", ref_rd(1'b1, 64'h8000_0010), 64'd0);
    rc = n_rcall32;
    fork
      rd32(64'h8000_0010, d, r, lat);
      wr32(64'h8000_0010, 32'd5, 4'hF, r2, lat2);
    join
    ref_wr(1'b1, 64'h8000_0010, 64'd5, 8'h0F);
    chk("t5_rdata", d, ref_rd(1'b1, 64'h8000_0010));
    chk("t5_rcall", 64'(n_rcall32 - rc), 64'd1);

    // Zero strobe: response without a memory write; partial strobe merge
    wc = n_wcall64;
    wr64(64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, r, lat);
    chk("ws0_bresp", 64'(r), 64'd0);
    chk("ws0_nocall", 64'(n_wcall64 - wc), 64'd0);
    chk("ws0_lat", 64'(lat), 64'd4);
    wr64(64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, r, lat);
    ref_wr(1'b0, 64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    rd64(64'h8000_0000, d, r, lat);
    chk("strb_merge", d, ref_rd(1'b0, 64'h8000_0000));

    // Unaligned 64-bit read
    rc = n_rcall64;
    rd64(64'h8000_0003, d, r, lat);
    chk("t6_lat", 64'(lat), 64'd4);
`ifdef DPIC_MEM_ALIGN_CHK_EN
    chk("t6_rresp", 64'(r), 64'd1);
    chk("t6_rdata", d, 64'd0);
    chk("t6_calls", 64'(n_rcall64 - rc), 64'd0);
`else
    chk("t6_rresp", 64'(r), 64'd0);
    chk("t6_rdata", d, ref_rd(1'b0, 64'h8000_0000));
    chk("t6_calls", 64'(n_rcall64 - rc), 64'd1);
`endif

    // Random traffic on both ports against the reference model
    for (int k = 0; k < 24; k++) begin
      a = 64'h8000_1000 + 64'(8 * $urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        s = (k % 5 == 0) ? 8'h00 : 8'($urandom);
        wr64(a, d, s, r, lat);
        ref_wr(1'b0, a, d, s);
        chk("rnd64_bresp", 64'(r), 64'd0);
      end else begin
        rd64(a, d, r, lat);
        chk("rnd64_rdata", d, ref_rd(1'b0, a));
        chk("rnd64_rlat",  64'(lat), 64'd4);
      end
      a = 64'h8000_2000 + 64'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        lo = $urandom;
        s  = 8'($urandom_range(0, 15));
        wr32(a, lo, s[3:0], r, lat);
        ref_wr(1'b1, a, 64'(lo), s);
        chk("rnd32_wlat", 64'(lat), 64'd2);
      end else begin
        rd32(a, d2, r, lat);
        chk("rnd32_rdata", d2, ref_rd(1'b1, a));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
